// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle
// Purpose  : Multi-cycle control unit for a small RV64I subset:
//            add, sub, addi, ld, sd, beq, jal, jalr and auipc.
//            It owns the program counter and the instruction register, and
//            drives the register-bank, ALU and data-memory controls.
// Ports    : clk, rst_n (synchronous, active low)
//            instr   - instruction memory output, valid in DECOD
//            imm     - immediate chosen externally through sel_imm
//            doutULA - ALU result, zero - doutULA == 0
//            endr    - instruction memory address (pc[8:2]); pc - current pc
//            Ra/Rb/Rw, WeR, WeM - register bank / data memory controls
//            soma_ou_subtrai, subtraindo, imediato, sel_imm, sel_dinR - datapath
//            dado_pc - link / auipc value; erro - trapped; estado - FSM debug
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [63:0] imm,
    input  logic [63:0] doutULA,
    input  logic        zero,
    output logic [6:0]  endr,
    output logic [63:0] pc,
    output logic [4:0]  Ra,
    output logic [4:0]  Rb,
    output logic [4:0]  Rw,
    output logic        WeR,
    output logic        WeM,
    output logic        soma_ou_subtrai,
    output logic        subtraindo,
    output logic        imediato,
    output logic [2:0]  sel_imm,
    output logic [1:0]  sel_dinR,
    output logic [63:0] dado_pc,
    output logic        erro,
    output logic [2:0]  estado
);

    // FSM encoding (also visible on the estado debug port)
    localparam logic [2:0] c_BUSCA   = 3'd0;
    localparam logic [2:0] c_DECOD   = 3'd1;
    localparam logic [2:0] c_EXEC    = 3'd2;
    localparam logic [2:0] c_MEM     = 3'd3;
    localparam logic [2:0] c_ESCRITA = 3'd4;
    localparam logic [2:0] c_ERRO    = 3'd5;

    // One-hot positions of the decoded instruction class
    localparam int c_D_ADD   = 0;
    localparam int c_D_SUB   = 1;
    localparam int c_D_ADDI  = 2;
    localparam int c_D_LD    = 3;
    localparam int c_D_SD    = 4;
    localparam int c_D_BEQ   = 5;
    localparam int c_D_JAL   = 6;
    localparam int c_D_JALR  = 7;
    localparam int c_D_AUIPC = 8;

    // Full decode (opcode + funct3 + funct7). An all-zero result means the
    // word is outside the supported set, which is how DECOD spots illegal
    // instructions using the very same table that later drives the datapath.
    function automatic logic [8:0] f_decode(input logic [31:0] w);
        logic [8:0] d;
        d = 9'd0;
        d[c_D_ADD]   = (w[6:0] == 7'b0110011) && (w[14:12] == 3'b000) && (w[31:25] == 7'b0000000);
        d[c_D_SUB]   = (w[6:0] == 7'b0110011) && (w[14:12] == 3'b000) && (w[31:25] == 7'b0100000);
        d[c_D_ADDI]  = (w[6:0] == 7'b0010011) && (w[14:12] == 3'b000);
        d[c_D_LD]    = (w[6:0] == 7'b0000011) && (w[14:12] == 3'b011);
        d[c_D_SD]    = (w[6:0] == 7'b0100011) && (w[14:12] == 3'b011);
        d[c_D_BEQ]   = (w[6:0] == 7'b1100011) && (w[14:12] == 3'b000);
        d[c_D_JAL]   = (w[6:0] == 7'b1101111);
        d[c_D_JALR]  = (w[6:0] == 7'b1100111) && (w[14:12] == 3'b000);
        d[c_D_AUIPC] = (w[6:0] == 7'b0010111);
        return d;
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [63:0] r_pc;
    logic [31:0] r_ir;
    logic [63:0] r_npc;       // next pc captured in EXEC, committed later
    logic [8:0]  w_dec;
    logic [63:0] w_pc_plus4;
    logic [63:0] w_pc_imm;
    logic [63:0] w_npc_calc;
    logic        w_misalign;
    logic        w_active;
    logic        w_pc_we;
    logic [63:0] w_pc_next;

    // Everything after DECOD is decoded from the latched IR only
    assign w_dec      = f_decode(r_ir);
    assign w_pc_plus4 = r_pc + 64'd4;
    assign w_pc_imm   = r_pc + imm;
    assign w_misalign = |w_npc_calc[1:0];
    assign w_active   = (r_state == c_EXEC) || (r_state == c_MEM) || (r_state == c_ESCRITA);

    assign endr   = r_pc[8:2];
    assign pc     = r_pc;
    assign Ra     = r_ir[19:15];
    assign Rb     = r_ir[24:20];
    assign Rw     = r_ir[11:7];
    assign estado = r_state;

    // Next-pc candidate; only meaningful while in EXEC (imm/doutULA/zero
    // are driven for the current instruction there)
    always_comb begin
        w_npc_calc = w_pc_plus4;
        if (w_dec[c_D_JAL] || (w_dec[c_D_BEQ] && zero)) begin
            w_npc_calc = w_pc_imm;
        end
        if (w_dec[c_D_JALR]) begin
            w_npc_calc = doutULA & ~64'd1;
        end
    end

    // Next state and all control outputs
    always_comb begin
        w_next_state    = r_state;
        w_pc_we         = 1'b0;
        w_pc_next       = r_npc;
        soma_ou_subtrai = w_active;
        subtraindo      = w_active && (w_dec[c_D_SUB] || w_dec[c_D_BEQ]);
        imediato        = w_active && (w_dec[c_D_ADDI] || w_dec[c_D_LD] ||
                                       w_dec[c_D_SD]   || w_dec[c_D_JALR]);
        sel_imm         = 3'd0;
        sel_dinR        = 2'd0;
        dado_pc         = w_dec[c_D_AUIPC] ? w_pc_imm : w_pc_plus4;
        erro            = (r_state == c_ERRO);
        // Write enables are gated by rst_n so a reset landing in ESCRITA or
        // MEM can never leak a write into the register bank or memory
        WeR             = rst_n && (r_state == c_ESCRITA) && (r_ir[11:7] != 5'd0);
        WeM             = rst_n && (r_state == c_MEM) && w_dec[c_D_SD];

        if (w_dec[c_D_SD]) begin
            sel_imm = 3'd1;
        end else if (w_dec[c_D_BEQ]) begin
            sel_imm = 3'd2;
        end else if (w_dec[c_D_JAL]) begin
            sel_imm = 3'd3;
        end else if (w_dec[c_D_AUIPC]) begin
            sel_imm = 3'd4;
        end

        if (w_dec[c_D_LD]) begin
            sel_dinR = 2'd1;
        end else if (w_dec[c_D_JAL] || w_dec[c_D_JALR] || w_dec[c_D_AUIPC]) begin
            sel_dinR = 2'd2;
        end

        case (r_state)
            c_BUSCA: w_next_state = c_DECOD;
            c_DECOD: w_next_state = (|f_decode(instr)) ? c_EXEC : c_ERRO;
            c_EXEC: begin
                // A misaligned target traps before any pc or register update
                if (w_misalign) begin
                    w_next_state = c_ERRO;
                end else if (w_dec[c_D_BEQ]) begin
                    w_next_state = c_BUSCA;
                    w_pc_we      = 1'b1;
                    w_pc_next    = w_npc_calc;
                end else if (w_dec[c_D_LD] || w_dec[c_D_SD]) begin
                    w_next_state = c_MEM;
                end else begin
                    w_next_state = c_ESCRITA;
                end
            end
            c_MEM: begin
                if (w_dec[c_D_LD]) begin
                    w_next_state = c_ESCRITA;
                end else begin
                    w_next_state = c_BUSCA;
                    w_pc_we      = 1'b1;
                end
            end
            c_ESCRITA: begin
                w_next_state = c_BUSCA;
                w_pc_we      = 1'b1;
            end
            c_ERRO:  w_next_state = c_ERRO;
            default: w_next_state = c_ERRO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_BUSCA;
            r_pc    <= 64'd0;
            r_ir    <= 32'd0;
            r_npc   <= 64'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_DECOD) begin
                r_ir <= instr;
            end
            if (r_state == c_EXEC) begin
                r_npc <= w_npc_calc;
            end
            if (w_pc_we) begin
                r_pc <= w_pc_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_controle
// Purpose  : Directed self-checking bench for unidade_controle. Each
//            instruction is run from BUSCA until the FSM returns to BUSCA
//            or traps; cycle count, write pulses and EXEC-time controls are
//            captured and compared with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_controle;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [63:0] doutULA;
    logic        zero;
    logic [6:0]  endr;
    logic [63:0] pc;
    logic [4:0]  Ra, Rb, Rw;
    logic        WeR, WeM;
    logic        soma_ou_subtrai, subtraindo, imediato;
    logic [2:0]  sel_imm;
    logic [1:0]  sel_dinR;
    logic [63:0] dado_pc;
    logic        erro;
    logic [2:0]  estado;

    int checks   = 0;
    int failures = 0;

    // Values captured by run_instr
    logic [63:0] ncyc, n_wer, n_wem, wer_cyc, pc_end, dpc_w;
    logic [4:0]  rw_w, ra_x, rb_x;
    logic [1:0]  dinr_w;
    logic [2:0]  st_end, simm_x;
    logic        sub_x, imed_x, soma_x, done;

    unidade_controle dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr           (instr),
        .imm             (imm),
        .doutULA         (doutULA),
        .zero            (zero),
        .endr            (endr),
        .pc              (pc),
        .Ra              (Ra),
        .Rb              (Rb),
        .Rw              (Rw),
        .WeR             (WeR),
        .WeM             (WeM),
        .soma_ou_subtrai (soma_ou_subtrai),
        .subtraindo      (subtraindo),
        .imediato        (imediato),
        .sel_imm         (sel_imm),
        .sel_dinR        (sel_dinR),
        .dado_pc         (dado_pc),
        .erro            (erro),
        .estado          (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge where the FSM is in BUSCA; returns at the negedge
    // where it is back in BUSCA or in ERRO.
    task automatic run_instr(input string tag, input logic [31:0] ins,
                             input logic [63:0] immv, input logic [63:0] alu,
                             input logic z);
        instr = ins; imm = immv; doutULA = alu; zero = z;
        ncyc = 0; n_wer = 0; n_wem = 0; wer_cyc = 0; dpc_w = 0;
        rw_w = 0; ra_x = 0; rb_x = 0; dinr_w = 0; simm_x = 0;
        sub_x = 0; imed_x = 0; soma_x = 0; done = 0;
        chk({tag, "_entry_state"}, 64'(estado), 64'd0);
        for (int i = 0; i < 10; i++) begin
            ncyc++;
            if (WeR) begin
                n_wer++; wer_cyc = ncyc; rw_w = Rw; dinr_w = sel_dinR; dpc_w = dado_pc;
            end
            if (WeM) n_wem++;
            if (estado == 3'd2) begin
                sub_x = subtraindo; imed_x = imediato; soma_x = soma_ou_subtrai;
                simm_x = sel_imm; ra_x = Ra; rb_x = Rb;
            end
            @(negedge clk);
            if (estado == 3'd0 || estado == 3'd5) begin
                done = 1'b1;
                break;
            end
        end
        pc_end = pc; st_end = estado;
        chk({tag, "_terminated"}, 64'(done), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'd0; imm = 64'd0; doutULA = 64'd0; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_estado", 64'(estado), 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_erro", 64'(erro), 64'd0);
        chk("rst_wer_wem", 64'({WeR, WeM}), 64'd0);
        rst_n = 1'b1;
        chk("first_endr", 64'(endr), 64'd0);

        // addi x1,x0,5 at pc 0
        run_instr("addi", 32'h0050_0093, 64'd5, 64'd5, 1'b0);
        chk("addi_cycles", ncyc, 64'd4);
        chk("addi_wer_count", n_wer, 64'd1);
        chk("addi_rw", 64'(rw_w), 64'd1);
        chk("addi_imediato", 64'(imed_x), 64'd1);
        chk("addi_sel_imm", 64'(simm_x), 64'd0);
        chk("addi_soma", 64'(soma_x), 64'd1);
        chk("addi_pc", pc_end, 64'd4);
        chk("addi_endr", 64'(endr), 64'd1);

        // sub x4,x1,x3 at pc 4
        run_instr("sub", 32'h4030_8233, 64'd0, 64'd2, 1'b0);
        chk("sub_subtraindo", 64'(sub_x), 64'd1);
        chk("sub_imediato", 64'(imed_x), 64'd0);
        chk("sub_ra_rb", 64'({ra_x, rb_x}), 64'({5'd1, 5'd3}));
        chk("sub_wer_cycle", wer_cyc, 64'd4);
        chk("sub_rw", 64'(rw_w), 64'd4);
        chk("sub_sel_dinR", 64'(dinr_w), 64'd0);
        chk("sub_pc", pc_end, 64'd8);

        // beq x1,x1,-8 at pc 8, taken
        run_instr("beq_t", 32'hFE10_8CE3, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1);
        chk("beq_t_cycles", ncyc, 64'd3);
        chk("beq_t_writes", n_wer + n_wem, 64'd0);
        chk("beq_t_subtraindo", 64'(sub_x), 64'd1);
        chk("beq_t_sel_imm", 64'(simm_x), 64'd2);
        chk("beq_t_pc", pc_end, 64'd0);

        // back to pc 8, then the same beq not taken
        run_instr("addi2", 32'h0050_0093, 64'd5, 64'd5, 1'b0);
        run_instr("sub2", 32'h4030_8233, 64'd0, 64'd2, 1'b0);
        chk("sub2_pc", pc_end, 64'd8);
        run_instr("beq_nt", 32'hFE10_8CE3, 64'hFFFF_FFFF_FFFF_FFF8, 64'd5, 1'b0);
        chk("beq_nt_cycles", ncyc, 64'd3);
        chk("beq_nt_pc", pc_end, 64'd12);

        // ld x2,16(x0) at pc 12
        run_instr("ld", 32'h0100_3103, 64'd16, 64'd16, 1'b0);
        chk("ld_cycles", ncyc, 64'd5);
        chk("ld_wem", n_wem, 64'd0);
        chk("ld_wer_count", n_wer, 64'd1);
        chk("ld_sel_dinR", 64'(dinr_w), 64'd1);
        chk("ld_rw", 64'(rw_w), 64'd2);
        chk("ld_pc", pc_end, 64'd16);

        // sd x2,8(x0) at pc 16
        run_instr("sd", 32'h0020_3423, 64'd8, 64'd8, 1'b0);
        chk("sd_cycles", ncyc, 64'd4);
        chk("sd_wem_count", n_wem, 64'd1);
        chk("sd_wer", n_wer, 64'd0);
        chk("sd_sel_imm", 64'(simm_x), 64'd1);
        chk("sd_pc", pc_end, 64'd20);

        // jalr x5,0(x6) at pc 0x14, target 0x21 -> 0x20
        run_instr("jalr", 32'h0003_02E7, 64'd0, 64'h21, 1'b0);
        chk("jalr_cycles", ncyc, 64'd4);
        chk("jalr_pc", pc_end, 64'h20);
        chk("jalr_dado_pc", dpc_w, 64'h18);
        chk("jalr_sel_dinR", 64'(dinr_w), 64'd2);
        chk("jalr_rw", 64'(rw_w), 64'd5);

        // auipc x7,0x1 at pc 0x20
        run_instr("auipc", 32'h0000_1397, 64'h1000, 64'd0, 1'b0);
        chk("auipc_dado_pc", dpc_w, 64'h1020);
        chk("auipc_sel_imm", 64'(simm_x), 64'd4);
        chk("auipc_pc", pc_end, 64'h24);

        // jal x1,+12 at pc 0x24
        run_instr("jal", 32'h00C0_00EF, 64'd12, 64'd0, 1'b0);
        chk("jal_dado_pc", dpc_w, 64'h28);
        chk("jal_sel_imm", 64'(simm_x), 64'd3);
        chk("jal_pc", pc_end, 64'h30);

        // jalr to misaligned 0x22 -> trap, pc stays 0x30
        run_instr("jalr_mis", 32'h0003_02E7, 64'd0, 64'h22, 1'b0);
        chk("jalr_mis_state", 64'(st_end), 64'd5);
        chk("jalr_mis_wer", n_wer, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("erro_hold", 64'({erro, WeR, WeM}), 64'b100);
            chk("erro_pc", pc, 64'h30);
            @(negedge clk);
        end

        // one reset edge leaves ERRO
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_estado", 64'(estado), 64'd0);
        chk("rst2_pc_erro", {pc[62:0], erro}, 64'd0);

        // illegal word traps right after DECOD
        run_instr("illegal", 32'hFFFF_FFFF, 64'd0, 64'd0, 1'b0);
        chk("illegal_cycles", ncyc, 64'd2);
        chk("illegal_state", 64'(st_end), 64'd5);
        chk("illegal_writes", n_wer + n_wem, 64'd0);
        @(negedge clk);
        chk("illegal_hold", 64'({erro, WeR, WeM}), 64'b100);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst3_state", 64'({estado, erro}), 64'd0);

        // pc wrap: jump to 0x..FC, then addi x0 (no write, pc wraps to 0)
        run_instr("jalr_top", 32'h0003_02E7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        chk("top_pc", pc_end, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("top_endr", 64'(endr), 64'h7F);
        run_instr("nop", 32'h0000_0013, 64'd0, 64'd0, 1'b0);
        chk("nop_wer_x0", n_wer, 64'd0);
        chk("wrap_pc", pc_end, 64'd0);

        // reset asserted while ld is in ESCRITA
        instr = 32'h0100_3103; imm = 64'd16; doutULA = 64'd16;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("ldr_in_escrita", 64'(estado), 64'd4);
        chk("ldr_wer_before", 64'(WeR), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ldr_wer_in_reset", 64'({WeR, WeM}), 64'd0);
        @(negedge clk);
        chk("ldr_wer_reset_edge", 64'(WeR), 64'd0);
        rst_n = 1'b1;
        chk("ldr_after_state", 64'(estado), 64'd0);
        chk("ldr_after_pc", pc, 64'd0);
        chk("ldr_after_endr", 64'(endr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
